// File: rtl/adc_spi_responder.sv
// SPI slave emulating an 8-channel serial ADC for hardware-in-loop self-test.
// Frame N returns the conversion for the channel addressed by frame N-1.
module adc_spi_responder #(
    parameter int ADC_WIDTH   = 10,
    parameter int FRAME_BITS  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        aclr,
    input  logic                        sclr,
    input  logic                        sclk,
    input  logic                        csn,
    input  logic                        mosi,
    output logic                        miso,
    output logic                        miso_oe,
    input  logic [7:0][ADC_WIDTH-1:0]   ch_data,
    input  logic [7:0]                  ch_err,
    output logic [FRAME_BITS-1:0]       rx_word,
    output logic                        frame_done,
    output logic                        frame_err,
    output logic [2:0]                  cur_ch,
    output logic [15:0]                 frame_cnt
);

    localparam int PAD = FRAME_BITS - ADC_WIDTH - 5;
    localparam int CW  = $clog2(FRAME_BITS + 2);
    localparam logic [CW-1:0] BITS_FULL = CW'(FRAME_BITS);
    localparam logic [CW-1:0] BITS_MAX  = CW'(FRAME_BITS + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_END} state_t;

    // Synchronizers reset to 0 so that a csn held low across a reset
    // cannot look like a fresh falling edge.
    logic [SYNC_STAGES-1:0] sclk_sync_reg, sclk_sync_next;
    logic [SYNC_STAGES-1:0] csn_sync_reg, csn_sync_next;
    logic [SYNC_STAGES-1:0] mosi_sync_reg, mosi_sync_next;
    logic                   sclk_d_reg, sclk_d_next;
    logic                   csn_d_reg, csn_d_next;

    state_t                 state_reg, state_next;
    logic [CW-1:0]          bit_cnt_reg, bit_cnt_next;
    logic [FRAME_BITS-1:0]  tx_shift_reg, tx_shift_next;
    logic [FRAME_BITS-1:0]  rx_shift_reg, rx_shift_next;
    logic                   miso_reg, miso_next;
    logic                   miso_oe_reg, miso_oe_next;
    logic [FRAME_BITS-1:0]  rx_word_reg, rx_word_next;
    logic                   frame_done_reg, frame_done_next;
    logic                   frame_err_reg, frame_err_next;
    logic [2:0]             cur_ch_reg, cur_ch_next;
    logic [15:0]            frame_cnt_reg, frame_cnt_next;
    logic                   pend_reg, pend_next;

    logic s_sclk, s_csn, s_mosi;
    logic sclk_rise, sclk_fall, csn_rise, csn_fall;
    logic [FRAME_BITS-1:0] load_word;

    assign s_sclk    = sclk_sync_reg[SYNC_STAGES-1];
    assign s_csn     = csn_sync_reg[SYNC_STAGES-1];
    assign s_mosi    = mosi_sync_reg[SYNC_STAGES-1];
    assign sclk_rise = s_sclk & ~sclk_d_reg;
    assign sclk_fall = ~s_sclk & sclk_d_reg;
    assign csn_rise  = s_csn & ~csn_d_reg;
    assign csn_fall  = ~s_csn & csn_d_reg;

    assign load_word = FRAME_BITS'({1'b0, cur_ch_reg, ch_err[cur_ch_reg], ch_data[cur_ch_reg]}) << PAD;

    always_comb begin
        sclk_sync_next  = {sclk_sync_reg[SYNC_STAGES-2:0], sclk};
        csn_sync_next   = {csn_sync_reg[SYNC_STAGES-2:0], csn};
        mosi_sync_next  = {mosi_sync_reg[SYNC_STAGES-2:0], mosi};
        sclk_d_next     = s_sclk;
        csn_d_next      = s_csn;
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        tx_shift_next   = tx_shift_reg;
        rx_shift_next   = rx_shift_reg;
        miso_next       = miso_reg;
        miso_oe_next    = miso_oe_reg;
        rx_word_next    = rx_word_reg;
        frame_done_next = 1'b0;
        frame_err_next  = 1'b0;
        cur_ch_next     = cur_ch_reg;
        frame_cnt_next  = frame_cnt_reg;
        pend_next       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                miso_next    = 1'b0;
                miso_oe_next = 1'b0;
                if (csn_fall || pend_reg) begin
                    tx_shift_next = load_word;
                    miso_next     = load_word[FRAME_BITS-1];
                    miso_oe_next  = 1'b1;
                    bit_cnt_next  = '0;
                    state_next    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // csn takes priority over a coincident sclk edge
                if (csn_rise) begin
                    miso_next    = 1'b0;
                    miso_oe_next = 1'b0;
                    state_next   = ST_END;
                end else if (sclk_rise) begin
                    rx_shift_next = {rx_shift_reg[FRAME_BITS-2:0], s_mosi};
                    if (bit_cnt_reg != BITS_MAX)
                        bit_cnt_next = bit_cnt_reg + CW'(1);
                end else if (sclk_fall) begin
                    tx_shift_next = tx_shift_reg << 1;
                    miso_next     = tx_shift_reg[FRAME_BITS-2];
                end
            end
            ST_END: begin
                miso_next    = 1'b0;
                miso_oe_next = 1'b0;
                pend_next    = csn_fall;
                state_next   = ST_IDLE;
                if (bit_cnt_reg == BITS_FULL) begin
                    rx_word_next    = rx_shift_reg;
                    frame_done_next = 1'b1;
                    frame_cnt_next  = frame_cnt_reg + 16'd1;
                    if (rx_shift_reg[FRAME_BITS-1])
                        cur_ch_next = rx_shift_reg[FRAME_BITS-2 -: 3];
                end else begin
                    frame_err_next = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (sclr) begin
            sclk_sync_next  = '0;
            csn_sync_next   = '0;
            mosi_sync_next  = '0;
            sclk_d_next     = 1'b0;
            csn_d_next      = 1'b0;
            state_next      = ST_IDLE;
            bit_cnt_next    = '0;
            tx_shift_next   = '0;
            rx_shift_next   = '0;
            miso_next       = 1'b0;
            miso_oe_next    = 1'b0;
            rx_word_next    = '0;
            frame_done_next = 1'b0;
            frame_err_next  = 1'b0;
            cur_ch_next     = '0;
            frame_cnt_next  = '0;
            pend_next       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            sclk_sync_reg  <= '0;
            csn_sync_reg   <= '0;
            mosi_sync_reg  <= '0;
            sclk_d_reg     <= 1'b0;
            csn_d_reg      <= 1'b0;
            state_reg      <= ST_IDLE;
            bit_cnt_reg    <= '0;
            tx_shift_reg   <= '0;
            rx_shift_reg   <= '0;
            miso_reg       <= 1'b0;
            miso_oe_reg    <= 1'b0;
            rx_word_reg    <= '0;
            frame_done_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            cur_ch_reg     <= '0;
            frame_cnt_reg  <= '0;
            pend_reg       <= 1'b0;
        end else begin
            sclk_sync_reg  <= sclk_sync_next;
            csn_sync_reg   <= csn_sync_next;
            mosi_sync_reg  <= mosi_sync_next;
            sclk_d_reg     <= sclk_d_next;
            csn_d_reg      <= csn_d_next;
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            tx_shift_reg   <= tx_shift_next;
            rx_shift_reg   <= rx_shift_next;
            miso_reg       <= miso_next;
            miso_oe_reg    <= miso_oe_next;
            rx_word_reg    <= rx_word_next;
            frame_done_reg <= frame_done_next;
            frame_err_reg  <= frame_err_next;
            cur_ch_reg     <= cur_ch_next;
            frame_cnt_reg  <= frame_cnt_next;
            pend_reg       <= pend_next;
        end
    end

    assign miso       = miso_reg;
    assign miso_oe    = miso_oe_reg;
    assign rx_word    = rx_word_reg;
    assign frame_done = frame_done_reg;
    assign frame_err  = frame_err_reg;
    assign cur_ch     = cur_ch_reg;
    assign frame_cnt  = frame_cnt_reg;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Self-checking bench for adc_spi_responder: SPI master driver, fixed vector
// table, corner-case sequences and randomized frames against a frame-level model.
module tb_adc_spi_responder;

    localparam int AW = 10;
    localparam int FB = 16;

    logic                clk = 1'b0;
    logic                aclr = 1'b1;
    logic                sclr = 1'b0;
    logic                sclk = 1'b0;
    logic                csn = 1'b1;
    logic                mosi = 1'b0;
    logic                miso, miso_oe;
    logic [7:0][AW-1:0]  ch_data = '0;
    logic [7:0]          ch_err = '0;
    logic [FB-1:0]       rx_word;
    logic                frame_done, frame_err;
    logic [2:0]          cur_ch;
    logic [15:0]         frame_cnt;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    // frame-level model state
    logic [2:0]  m_ch = '0;
    logic [15:0] m_cnt = '0;
    logic [15:0] m_rxw = '0;

    adc_spi_responder #(.ADC_WIDTH(AW), .FRAME_BITS(FB), .SYNC_STAGES(2)) dut (
        .clk(clk), .aclr(aclr), .sclr(sclr), .sclk(sclk), .csn(csn), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .ch_data(ch_data), .ch_err(ch_err),
        .rx_word(rx_word), .frame_done(frame_done), .frame_err(frame_err),
        .cur_ch(cur_ch), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (frame_err) err_cnt++;
        if (frame_done && frame_err) both_cnt++;
    end

    typedef struct {
        logic [15:0] mosi_w;
        int          nbits;
        logic [15:0] exp_miso;
        logic [2:0]  exp_ch;
        logic [15:0] exp_cnt;
        logic [15:0] exp_rxw;
        int          exp_done;
        int          exp_err;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {0, ch, err, data, pad} computed arithmetically from field positions
    function automatic logic [15:0] ref_word(input logic [2:0] ch, input logic e, input logic [AW-1:0] d);
        int w;
        w = (int'(ch) << (FB - 4)) + (int'(e) << (FB - 5)) + (int'(d) << (FB - 5 - AW));
        return w[15:0];
    endfunction

    task automatic cmp_miso(input int nbits, input logic [31:0] got, input logic [15:0] exp);
        if (nbits >= FB) begin
            check("miso_word", (got >> (nbits - FB)) & 32'hFFFF, {16'h0, exp});
            if (nbits > FB)
                check("miso_tail", got & ((32'd1 << (nbits - FB)) - 32'd1), 32'd0);
        end else begin
            check("miso_prefix", got & ((32'd1 << nbits) - 32'd1), {16'h0, exp} >> (FB - nbits));
        end
    endtask

    task automatic spi_frame(input logic [15:0] word, input int nbits, input int mod_at,
                             input int clr_at, input bit coinc_end, output logic [31:0] got);
        got = '0;
        csn = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == mod_at) begin
                for (int k = 0; k < 8; k++) ch_data[k] = ~ch_data[k];
                ch_err = ~ch_err;
            end
            if (i == clr_at) begin
                sclr = 1'b1;
                @(negedge clk);
                sclr = 1'b0;
                check("sclr_oe", {31'd0, miso_oe}, 32'd0);
                check("sclr_miso", {31'd0, miso}, 32'd0);
            end
            mosi = (i < FB) ? word[FB-1-i] : 1'b0;
            repeat (2) @(negedge clk);
            got = {got[30:0], miso};
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
            repeat (2) @(negedge clk);
        end
        if (coinc_end) sclk = 1'b1;
        csn = 1'b1;
        repeat (3) @(negedge clk);
        check("oe_after_csn", {31'd0, miso_oe}, 32'd0);
        sclk = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic run_check(input string tag, input logic [15:0] word, input int nbits,
                             input int mod_at, input int clr_at, input bit coinc_end);
        logic [31:0] got;
        logic [15:0] exp;
        int d0, e0;
        bit valid;
        exp = ref_word(m_ch, ch_err[m_ch], ch_data[m_ch]);
        d0 = done_cnt;
        e0 = err_cnt;
        spi_frame(word, nbits, mod_at, clr_at, coinc_end, got);
        if (clr_at >= 0) begin
            m_ch = '0;
            m_cnt = '0;
            m_rxw = '0;
            check("clr_no_done", done_cnt - d0, 32'd0);
            check("clr_no_err", err_cnt - e0, 32'd0);
        end else begin
            valid = (nbits == FB);
            cmp_miso(nbits, got, exp);
            if (valid) begin
                m_cnt = m_cnt + 16'd1;
                m_rxw = word;
                if (word[15]) m_ch = word[14:12];
            end
            check("done_pulse", done_cnt - d0, valid ? 32'd1 : 32'd0);
            check("err_pulse", err_cnt - e0, valid ? 32'd0 : 32'd1);
        end
        check("cur_ch", {29'd0, cur_ch}, {29'd0, m_ch});
        check("frame_cnt", {16'd0, frame_cnt}, {16'd0, m_cnt});
        check("rx_word", {16'd0, rx_word}, {16'd0, m_rxw});
        $display("frame %s mosi=%h bits=%0d miso=%h exp=%h cur_ch=%0d cnt=%0d",
                 tag, word, nbits, got[15:0], exp, cur_ch, frame_cnt);
    endtask

    initial begin
        logic [31:0] got;
        int d0, e0, nb;

        // reset state
        repeat (3) @(negedge clk);
        aclr = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_oe", {31'd0, miso_oe}, 32'd0);
        check("rst_rx_word", {16'd0, rx_word}, 32'd0);
        check("rst_cur_ch", {29'd0, cur_ch}, 32'd0);
        check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        check("rst_pulses", done_cnt + err_cnt, 32'd0);

        // channel pipeline, abort and overrun vectors
        ch_data[3] = 10'h333;
        ch_err[3]  = 1'b1;
        ch_data[0] = 10'h111;
        tbl[0] = '{16'hB000, 16, 16'h0222, 3'd3, 16'd1, 16'hB000, 1, 0};
        tbl[1] = '{16'h0000, 16, 16'h3E66, 3'd3, 16'd2, 16'h0000, 1, 0};
        tbl[2] = '{16'h9000,  9, 16'h3E66, 3'd3, 16'd2, 16'h0000, 0, 1};
        tbl[3] = '{16'hF000, 18, 16'h3E66, 3'd3, 16'd2, 16'h0000, 0, 1};
        tbl[4] = '{16'h9000, 16, 16'h3E66, 3'd1, 16'd3, 16'h9000, 1, 0};
        tbl[5] = '{16'h0000, 16, 16'h1000, 3'd1, 16'd4, 16'h0000, 1, 0};
        for (int i = 0; i < 6; i++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            spi_frame(tbl[i].mosi_w, tbl[i].nbits, -1, -1, 1'b0, got);
            cmp_miso(tbl[i].nbits, got, tbl[i].exp_miso);
            check("tbl_done", done_cnt - d0, tbl[i].exp_done);
            check("tbl_err", err_cnt - e0, tbl[i].exp_err);
            check("tbl_cur_ch", {29'd0, cur_ch}, {29'd0, tbl[i].exp_ch});
            check("tbl_frame_cnt", {16'd0, frame_cnt}, {16'd0, tbl[i].exp_cnt});
            check("tbl_rx_word", {16'd0, rx_word}, {16'd0, tbl[i].exp_rxw});
            $display("vector %0d mosi=%h bits=%0d miso=%h cur_ch=%0d cnt=%0d",
                     i, tbl[i].mosi_w, tbl[i].nbits, got[15:0], cur_ch, frame_cnt);
        end
        m_ch  = 3'd1;
        m_cnt = 16'd4;
        m_rxw = 16'h0000;

        // snapshot: inputs change mid-frame, shifted word keeps the latched value
        run_check("snapshot", 16'hA000, 16, 6, -1, 1'b0);
        // csn rise coincident with a 17th sclk rise: that edge is not counted
        run_check("coinc_end", 16'hC000, 16, -1, -1, 1'b1);

        // randomized frames
        for (int n = 0; n < 24; n++) begin
            for (int k = 0; k < 8; k++) ch_data[k] = AW'($urandom_range(0, 1023));
            ch_err = 8'($urandom);
            case ($urandom_range(0, 7))
                0: nb = 9;
                1: nb = 18;
                2: nb = 1;
                3: nb = 17;
                default: nb = 16;
            endcase
            run_check("random", 16'($urandom), nb, -1, -1, 1'b0);
        end

        // sclr mid-frame
        run_check("sclr_mid", 16'hB000, 16, -1, 5, 1'b0);
        run_check("after_sclr", 16'h8000, 16, -1, -1, 1'b0);

        // frame counter wrap
        @(negedge clk);
        force dut.frame_cnt_reg = 16'hFFFE;
        @(negedge clk);
        release dut.frame_cnt_reg;
        m_cnt = 16'hFFFE;
        @(negedge clk);
        check("preset_cnt", {16'd0, frame_cnt}, 32'h0000FFFE);
        run_check("wrap_1", 16'h0000, 16, -1, -1, 1'b0);
        run_check("wrap_2", 16'h0000, 16, -1, -1, 1'b0);
        check("wrap_zero", {16'd0, frame_cnt}, 32'd0);

        check("pulse_exclusive", both_cnt, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
